counter_run_controller: RTL

Sequences the team's WIDTH-bit up-counter through repeated count passes. Accepts a command holding a terminal value and a pass count, then drives the counter's clear and enable. It detects the terminal count, reports completion, and watches for a stalled counter. It sits between the control/test logic and the counter datapath, and owns the counter's clear and enable exclusively.

---
 rtl/counter_ctrl_pkg.sv | 15 +
 rtl/counter_stall_watchdog.sv | 40 ++++
 rtl/counter_run_controller.sv | 103 ++++++++++
 3 files changed

// File: rtl/counter_ctrl_pkg.sv
// Shared types and default sizes for the counter run controller and its stall watchdog.
package counter_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        RUN,
        DONE
    } ctrl_state_e;

    localparam int WIDTH_DEF       = 4;
    localparam int PW_DEF          = 4;
    localparam int STALL_LIMIT_DEF = 3;

endpackage

// File: rtl/counter_stall_watchdog.sv
// Flags a counter that was enabled but did not move for STALL_LIMIT consecutive cycles.
module counter_stall_watchdog
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEF,
    parameter int STALL_LIMIT = STALL_LIMIT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             active,
    input  logic             en_prev,
    input  logic [WIDTH-1:0] count,
    output logic             stall
);

    localparam int SW = $clog2(STALL_LIMIT + 1);

    logic [WIDTH-1:0] prev_q;
    logic [SW-1:0]    sc_q;
    logic             same;

    // A wrap such as max -> 0 differs from the previous value, so it counts as movement.
    assign same  = (count == prev_q);
    assign stall = active && en_prev && same && (sc_q == SW'(STALL_LIMIT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q <= '0;
            sc_q   <= '0;
        end else begin
            prev_q <= count;
            if (!active || !same) begin
                sc_q <= '0;
            end else if (en_prev && !stall) begin
                sc_q <= sc_q + SW'(1);
            end
        end
    end

endmodule

// File: rtl/counter_run_controller.sv
// Runs the up-counter through a commanded number of passes to a terminal value,
// owning its clear/enable, reporting completion and aborting on a stalled counter.
module counter_run_controller
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEF,
    parameter int PW          = PW_DEF,
    parameter int STALL_LIMIT = STALL_LIMIT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_limit,
    input  logic [PW-1:0]    cmd_passes,
    input  logic             abort,
    input  logic [WIDTH-1:0] count,
    output logic             cnt_clr,
    output logic             cnt_en,
    output logic             busy,
    output logic [PW-1:0]    pass_idx,
    output logic             done,
    output logic             err
);

    ctrl_state_e      state;
    logic [WIDTH-1:0] limit_q;
    logic [PW-1:0]    passes_q;
    logic             en_prev_q;
    logic             terminal;
    logic             last_pass;
    logic             stall;

    assign terminal  = (count == limit_q);
    assign last_pass = (pass_idx == passes_q - PW'(1));

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign cnt_clr   = (state == CLEAR);
    assign cnt_en    = (state == RUN) && !terminal && !abort;
    // An abort arriving in DONE cancels the completion report.
    assign done      = (state == DONE) && !abort;

    counter_stall_watchdog #(
        .WIDTH       (WIDTH),
        .STALL_LIMIT (STALL_LIMIT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .active  (state == RUN),
        .en_prev (en_prev_q),
        .count   (count),
        .stall   (stall)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            limit_q   <= '0;
            passes_q  <= '0;
            pass_idx  <= '0;
            en_prev_q <= 1'b0;
            err       <= 1'b0;
        end else begin
            en_prev_q <= cnt_en;
            err       <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        limit_q  <= cmd_limit;
                        passes_q <= cmd_passes;
                        pass_idx <= '0;
                        state    <= (cmd_passes == '0) ? DONE : CLEAR;
                    end
                end
                CLEAR: begin
                    state <= abort ? IDLE : RUN;
                end
                RUN: begin
                    // Abort outranks terminal detection, which outranks the watchdog.
                    if (abort) begin
                        state <= IDLE;
                    end else if (terminal) begin
                        if (last_pass) begin
                            state <= DONE;
                        end else begin
                            pass_idx <= pass_idx + PW'(1);
                            state    <= CLEAR;
                        end
                    end else if (stall) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
